// File: rtl/wb_z80_bus.sv
// Wishbone B4 classic slave that runs single-byte Z80 memory/I/O bus cycles (T1,T2,TW*,T3).
// Latency: A valid at edge 0, strobes low at edge 1, ack at edge 2 (+1 per forced or nWAIT wait).
// Backpressure: a request is only accepted in IDLE; the Wishbone side is held off until T3 acks.
module wb_z80_bus #(
    parameter logic [7:0] IO_PAGE      = 8'hFF,
    parameter int         MEM_WAIT     = 0,
    parameter int         IO_WAIT      = 1,
    parameter int         WAIT_TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [23:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_sel_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] A,
    inout  wire  [7:0]  D,
    output logic        nMREQ,
    output logic        nIORQ,
    output logic        nRD,
    output logic        nWR,
    output logic        nM1,
    output logic        nRFSH,
    input  logic        nWAIT
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

    state_t      state_q, state_d;
    logic [15:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic [7:0]  dout_q, dout_d;
    logic [3:0]  fw_q, fw_d;
    logic [15:0] to_q, to_d;
    logic        abort_q, abort_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [7:0]  dat_q, dat_d;
    logic        mreq_n_q, iorq_n_q, rd_n_q, wr_n_q, d_oe_q;
    logic        bus_act;
    logic        timed_out;

    assign timed_out = (WAIT_TIMEOUT != 0) && (to_q == 16'(WAIT_TIMEOUT));

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        io_d    = io_q;
        dout_d  = dout_q;
        fw_d    = fw_q;
        to_d    = to_q;
        abort_d = abort_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d   = wb_adr_i[15:0];
                    we_d    = wb_we_i && wb_sel_i;
                    io_d    = (wb_adr_i[23:16] == IO_PAGE);
                    dout_d  = wb_dat_i;
                    fw_d    = io_d ? 4'(IO_WAIT) : 4'(MEM_WAIT);
                    to_d    = '0;
                    abort_d = 1'b0;
                    if (wb_sel_i) begin
                        state_d = S_T1;
                    end else begin
                        // No byte selected: skip the bus, ack through a strobe-less T3.
                        state_d = S_T3;
                        ack_d   = 1'b1;
                        dat_d   = 8'hFF;
                    end
                end
            end
            S_T1: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                state_d = S_T2;
            end
            S_T2, S_TW: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                if (fw_q != 4'd0) begin
                    fw_d    = fw_q - 4'd1;
                    state_d = S_TW;
                end else if (timed_out) begin
                    state_d = S_T3;
                    err_d   = wb_cyc_i && !abort_q;
                    dat_d   = 8'hFF;
                end else if (!nWAIT) begin
                    to_d    = to_q + 16'd1;
                    state_d = S_TW;
                end else begin
                    state_d = S_T3;
                    ack_d   = wb_cyc_i && !abort_q;
                    dat_d   = we_q ? 8'h00 : D;
                end
            end
            S_T3: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and the data driver are registered from the next state so the pins never glitch.
    assign bus_act = (state_d == S_T2) || (state_d == S_TW);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
            dout_q   <= '0;
            fw_q     <= '0;
            to_q     <= '0;
            abort_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= 8'h00;
            mreq_n_q <= 1'b1;
            iorq_n_q <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            d_oe_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            io_q     <= io_d;
            dout_q   <= dout_d;
            fw_q     <= fw_d;
            to_q     <= to_d;
            abort_q  <= abort_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            mreq_n_q <= !(bus_act && !io_d);
            iorq_n_q <= !(bus_act && io_d);
            rd_n_q   <= !(bus_act && !we_d);
            wr_n_q   <= !(bus_act && we_d);
            d_oe_q   <= we_d && (state_d != S_IDLE);
        end
    end

    assign A        = adr_q;
    assign D        = d_oe_q ? dout_q : 8'hzz;
    assign nMREQ    = mreq_n_q;
    assign nIORQ    = iorq_n_q;
    assign nRD      = rd_n_q;
    assign nWR      = wr_n_q;
    assign nM1      = 1'b1;
    assign nRFSH    = 1'b1;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_z80_bus.sv
// Directed bench for wb_z80_bus: reads, writes, waits, timeout, reset and abort.
module tb_wb_z80_bus;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i;
    logic [23:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [15:0] A;
    wire  [7:0]  D;
    logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;
    logic        nWAIT;
    logic [7:0]  tb_d;
    logic        tb_d_en;

    int vecs = 0;
    int errs = 0;

    // Weak pull-ups make a released bus read back as 8'hFF.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (D[i]);
    end
    assign D = tb_d_en ? tb_d : 8'hzz;

    always #5 CLK = ~CLK;

    wb_z80_bus #(
        .IO_PAGE(8'hFF), .MEM_WAIT(0), .IO_WAIT(1), .WAIT_TIMEOUT(4)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .A(A), .D(D),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nM1(nM1), .nRFSH(nRFSH), .nWAIT(nWAIT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [23:0] adr, input logic [7:0] dat, input logic sel);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // strobes packed as {nMREQ,nIORQ,nRD,nWR}
    function automatic logic [3:0] strb();
        return {nMREQ, nIORQ, nRD, nWR};
    endfunction

    initial begin
        RESET = 1'b1; nWAIT = 1'b1; tb_d = 8'h00; tb_d_en = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 1'b1;
        idle_bus();
        tick(); tick();
        RESET = 1'b0;

        // reset state
        check("rst_A", A, 16'h0000);
        check("rst_strobes", {strb(), nM1, nRFSH}, 6'b111111);
        check("rst_ack_err", {wb_ack_o, wb_err_o}, 2'b00);
        check("rst_dat", wb_dat_o, 8'h00);
        check("rst_D_released", D, 8'hFF);

        // memory read 0x001234
        tb_d = 8'hA5; tb_d_en = 1'b1;
        req(1'b0, 24'h001234, 8'h00, 1'b1);
        tick();
        check("mr_A", A, 16'h1234);
        check("mr_t1_strobes", strb(), 4'b1111);
        tick();
        check("mr_t2_strobes", strb(), 4'b0101);
        check("mr_t2_ack", wb_ack_o, 1'b0);
        tick();
        check("mr_ack", {wb_ack_o, wb_err_o}, 2'b10);
        check("mr_dat", wb_dat_o, 8'hA5);
        check("mr_t3_strobes", strb(), 4'b1111);
        idle_bus(); tb_d_en = 1'b0;
        tick();
        check("mr_ack_done", wb_ack_o, 1'b0);

        // memory write 0x00BEEF <- 0x3C
        req(1'b1, 24'h00BEEF, 8'h3C, 1'b1);
        tick();
        check("mw_A", A, 16'hBEEF);
        check("mw_t1_D", D, 8'h3C);
        tick();
        check("mw_t2_strobes", strb(), 4'b0110);
        check("mw_t2_D", D, 8'h3C);
        tick();
        check("mw_ack", wb_ack_o, 1'b1);
        check("mw_dat", wb_dat_o, 8'h00);
        check("mw_t3_D", D, 8'h3C);
        check("mw_t3_strobes", strb(), 4'b1111);
        idle_bus();
        tick();
        check("mw_D_released", D, 8'hFF);

        // I/O read 0xFF0042, one forced wait + two nWAIT waits
        tb_d = 8'hC3; tb_d_en = 1'b1; nWAIT = 1'b0;
        req(1'b0, 24'hFF0042, 8'h00, 1'b1);
        tick();
        check("io_A", A, 16'h0042);
        tick();
        check("io_t2_strobes", strb(), 4'b1001);
        tick();
        check("io_tw1_strobes", strb(), 4'b1001);
        tick();
        check("io_tw2_strobes", strb(), 4'b1001);
        tick();
        check("io_tw3_strobes", strb(), 4'b1001);
        check("io_tw3_ack", wb_ack_o, 1'b0);
        nWAIT = 1'b1; tb_d = 8'h5A;
        tick();
        check("io_ack", {wb_ack_o, wb_err_o}, 2'b10);
        check("io_dat", wb_dat_o, 8'h5A);
        check("io_t3_strobes", strb(), 4'b1111);
        idle_bus(); tb_d_en = 1'b0;
        tick();

        // timeout: nWAIT stuck low
        nWAIT = 1'b0;
        req(1'b0, 24'h000010, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("to_tw4_strobes", strb(), 4'b0101);
        check("to_tw4_err", wb_err_o, 1'b0);
        tick();
        check("to_err", {wb_ack_o, wb_err_o}, 2'b01);
        check("to_dat", wb_dat_o, 8'hFF);
        check("to_t3_strobes", strb(), 4'b1111);
        idle_bus();
        tick();
        check("to_err_done", wb_err_o, 1'b0);
        nWAIT = 1'b1;

        // reset during TW of a write
        nWAIT = 1'b0;
        req(1'b1, 24'h000500, 8'h99, 1'b1);
        tick(); tick(); tick();
        check("rw_tw_strobes", strb(), 4'b0110);
        RESET = 1'b1; idle_bus();
        tick();
        check("rw_strobes", strb(), 4'b1111);
        check("rw_D_released", D, 8'hFF);
        check("rw_no_ack", {wb_ack_o, wb_err_o}, 2'b00);
        RESET = 1'b0; nWAIT = 1'b1;
        tb_d = 8'h11; tb_d_en = 1'b1;
        req(1'b0, 24'h000777, 8'h00, 1'b1);
        tick();
        check("rw_next_A", A, 16'h0777);
        tick(); tick();
        check("rw_next_ack", wb_ack_o, 1'b1);
        check("rw_next_dat", wb_dat_o, 8'h11);
        idle_bus(); tb_d_en = 1'b0;
        tick();

        // wb_cyc_i dropped during T2
        tb_d = 8'h44; tb_d_en = 1'b1;
        req(1'b0, 24'h002000, 8'h00, 1'b1);
        tick(); tick();
        check("ab_t2_strobes", strb(), 4'b0101);
        idle_bus();
        tick();
        check("ab_t3_strobes", strb(), 4'b1111);
        check("ab_no_ack", {wb_ack_o, wb_err_o}, 2'b00);
        tick();
        tb_d = 8'h77;
        req(1'b0, 24'h003000, 8'h00, 1'b1);
        tick();
        check("ab_next_A", A, 16'h3000);
        tick(); tick();
        check("ab_next_ack", wb_ack_o, 1'b1);
        check("ab_next_dat", wb_dat_o, 8'h77);
        idle_bus(); tb_d_en = 1'b0;
        tick();

        // wb_sel_i = 0: no bus cycle, immediate ack with 0xFF
        req(1'b1, 24'h004000, 8'h12, 1'b0);
        tick();
        check("ns_ack", wb_ack_o, 1'b1);
        check("ns_dat", wb_dat_o, 8'hFF);
        check("ns_strobes", strb(), 4'b1111);
        check("ns_D_released", D, 8'hFF);
        idle_bus();
        tick();
        check("ns_ack_done", wb_ack_o, 1'b0);
        tick();
        check("ns_idle_strobes", strb(), 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wb_z80_bus.md
# wb_z80_bus

Wishbone B4 classic slave that turns single-byte Wishbone cycles into Z80-style memory or I/O bus cycles on an external 8-bit peripheral bus. It is the responder-side counterpart of the Z80-to-Wishbone bridge: it lets a Wishbone master in the fabric reach legacy Z80-bus peripherals and memories. It sits between the system Wishbone interconnect and the board-level Z80 bus pins. One bus state (T-state) lasts exactly one CLK cycle.

## Interface
- IO_PAGE, 8'hFF: a cycle is an I/O cycle when wb_adr_i[23:16] == IO_PAGE; otherwise it is a memory cycle.
- MEM_WAIT, 0: number of forced wait states inserted in memory cycles (0..15).
- IO_WAIT, 1: number of forced wait states inserted in I/O cycles (0..15).
- WAIT_TIMEOUT, 256: maximum number of nWAIT-extended wait states before the cycle aborts with an error; 0 disables the timeout.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  24  byte address.
- wb_dat_i  in  8  write data.
- wb_sel_i  in  1  byte select.
- wb_dat_o  out  8  read data; valid while wb_ack_o = 1.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error (wait timeout).
- A  out  16  Z80 address bus.
- D  inout  8  Z80 data bus; hi-Z unless this block is writing.
- nMREQ, nIORQ, nRD, nWR  out  1 each  active-low bus strobes.
- nM1, nRFSH  out  1 each  tied high. No opcode fetch or refresh is generated.
- nWAIT  in  1  active-low wait request from the peripheral. It is synchronous to CLK.

## Operation
- States: IDLE, T1, T2, TW, T3.
- IDLE
  - A new request (wb_cyc_i & wb_stb_i) is accepted only in IDLE.
  - On acceptance, latch wb_adr_i, wb_we_i, wb_dat_i and the I/O-or-memory decision. Load the forced-wait counter with MEM_WAIT or IO_WAIT. Go to T1.
  - If wb_sel_i = 0: no bus cycle is run. wb_ack_o pulses on the next cycle, wb_dat_o = 8'hFF, and the block returns to IDLE.
- T1
  - A = latched adr[15:0]. All strobes stay high.
  - For writes, D is driven with the latched data from T1 through T3.
- T2
  - Drive nMREQ low (memory cycle) or nIORQ low (I/O cycle).
  - Drive nRD low for a read or nWR low for a write.
- Leaving T2 or TW:
  - If the forced-wait counter is nonzero: decrement it and go to TW.
  - Else if nWAIT = 0: go to TW and increment the timeout counter.
  - Else: go to T3. For a read, capture D into wb_dat_o on this edge.
- Strobes stay low through every TW.
- T3
  - All strobes return high.
  - wb_ack_o = 1 for exactly this cycle; wb_dat_o holds the captured byte (read) or 8'h00 (write).
  - D is released at the end of T3. Next state is IDLE.
- Timeout: if the timeout counter reaches WAIT_TIMEOUT (nonzero), go to T3 regardless of nWAIT. In that T3, wb_err_o = 1 instead of wb_ack_o, and wb_dat_o = 8'hFF.
- Abort: if wb_cyc_i drops after acceptance, the Z80 cycle still runs to T3, because strobes are never truncated. wb_ack_o and wb_err_o are suppressed in that T3.
- RESET mid-cycle: on the next edge go to IDLE. Strobes go high and D is released immediately. No ack is given.

## Timing
- Reset values: A = 16'h0000; nMREQ, nIORQ, nRD, nWR, nM1, nRFSH = 1; D hi-Z; wb_ack_o = 0; wb_err_o = 0; wb_dat_o = 8'h00. All outputs are registered.
- Latency, with the request first sampled at edge 0:
  - edge 0: A valid.
  - edge 1: strobes low.
  - edge 2: read data captured, wb_ack_o rises. (This is with 0 forced waits and nWAIT = 1.)
  - edge 3: IDLE.
  - Each forced or nWAIT wait adds exactly one cycle.
- Minimum spacing between acks is 4 cycles.
- A classic master drops wb_stb_i on the edge where it sees the ack, so IDLE never re-accepts the same request. A master that keeps wb_stb_i high during the ack cycle is issuing a new request, and it is accepted in IDLE.
- nWAIT is sampled only on edges leaving T2 or TW. It is ignored in IDLE, T1 and T3.
- The forced-wait count and the timeout count are independent. The timeout counts only nWAIT-extended states.

## Test plan
- Memory read: adr 24'h001234, MEM_WAIT = 0, nWAIT = 1, D = 8'hA5 -> A = 16'h1234; nMREQ/nRD low for 1 cycle; ack 3 cycles after acceptance; wb_dat_o = 8'hA5; nIORQ stays high.
- Memory write: adr 24'h00BEEF, dat 8'h3C -> D = 8'h3C from T1 to T3; nWR low for 1 cycle; ack with wb_dat_o = 8'h00; D hi-Z afterwards.
- I/O read: adr 24'hFF0042, IO_WAIT = 1, nWAIT held low for 2 sampled edges -> nIORQ/nRD low for 4 cycles; ack at cycle 6; data captured on the edge nWAIT is first sampled high.
- Timeout: WAIT_TIMEOUT = 4, nWAIT stuck low -> wb_err_o pulses once after 4 TW states; wb_ack_o stays 0; wb_dat_o = 8'hFF; strobes high in T3.
- RESET asserted during TW of a write -> next edge: all strobes high, D hi-Z, state IDLE, no ack; a following read completes normally.
- wb_cyc_i dropped during T2 -> bus cycle still reaches T3; no ack or err; next request accepted from IDLE.
